rvvi_flow_ctrl: RTL and testbench

- Transmit-side flow controller for the RVVI Ethernet trace link.
- Consumes the host acknowledgement decoded by the inverse packetizer: ack valid, acknowledged minstret and requested inter-packet delay.
- Gates the RVVI packetizer with a credit window (instructions in flight) and a programmable inter-frame gap.
- Flags a stalled host by timeout.

---
 rtl/rvvi_flow_ctrl_pkg.sv | 19 +
 rtl/rvvi_gap_timer.sv | 27 ++
 rtl/rvvi_flow_ctrl.sv | 106 ++++++++++
 tb/tb_rvvi_flow_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_flow_ctrl_pkg.sv
// Shared types and constants for the RVVI trace-link flow controller.
// The delay width is shared with the inverse packetizer's delay field.
package rvvi_flow_ctrl_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 32'd64};

  localparam int RVVI_DELAYW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SENDING = 2'd1,
    GAP     = 2'd2
  } rvvi_fc_state_t;

endpackage

// File: rtl/rvvi_gap_timer.sv
// Loadable down-counter timing the inter-frame gap; done marks its final cycle.
module rvvi_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/rvvi_flow_ctrl.sv
// Transmit-side flow controller for the RVVI Ethernet trace link: credit window,
// programmable inter-frame gap, host-stall timeout and bad-ack detection.
module rvvi_flow_ctrl
  import rvvi_flow_ctrl_pkg::*;
#(
  parameter cvw_t P             = CVW_DEFAULT,
  parameter int   WINDOW        = 16,
  parameter int   DELAYW        = RVVI_DELAYW,
  parameter int   DEFAULT_DELAY = 0,
  parameter int   TIMEOUT_CYC   = 2**20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AckValid,
  input  logic [P.XLEN-1:0] AckMinstret,
  input  logic [DELAYW-1:0] AckDelay,
  input  logic              TxStart,
  input  logic [P.XLEN-1:0] TxMinstret,
  input  logic              TxDone,
  output logic              TxAllow,
  output logic [P.XLEN-1:0] Outstanding,
  output logic              Timeout,
  output logic              AckError
);

  localparam int XLEN = P.XLEN;
  localparam int TOW  = $clog2(TIMEOUT_CYC + 1);

  rvvi_fc_state_t    state_q;
  logic [XLEN-1:0]   sent_q, acked_q;
  logic [DELAYW-1:0] delay_q;
  logic [TOW-1:0]    to_cnt_q, to_cnt_d;
  logic              timeout_q, ack_err_q;

  logic [XLEN-1:0]   outstanding, d_ack;
  logic              tx_allow, tx_accept, ack_ok, ack_bad;
  logic              gap_load, gap_done;

  // Distances are taken from Acked so the window test survives minstret wrap-around.
  assign outstanding = sent_q - acked_q;
  assign d_ack       = AckMinstret - acked_q;
  assign ack_ok      = AckValid && (d_ack <= outstanding);
  assign ack_bad     = AckValid && (d_ack > outstanding);

  assign tx_allow  = (state_q == IDLE) && (outstanding < XLEN'(WINDOW));
  assign tx_accept = TxStart && tx_allow;
  assign gap_load  = (state_q == SENDING) && TxDone && (delay_q != '0);

  rvvi_gap_timer #(.W(DELAYW)) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (delay_q),
    .done_o     (gap_done)
  );

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (ack_ok || (outstanding == '0)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TOW'(TIMEOUT_CYC)) begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sent_q    <= '0;
      acked_q   <= '0;
      delay_q   <= DELAYW'(DEFAULT_DELAY);
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      if (tx_accept) sent_q <= TxMinstret;

      if (ack_ok) begin
        acked_q <= AckMinstret;
        delay_q <= AckDelay;
      end
      if (ack_bad) ack_err_q <= 1'b1;

      to_cnt_q <= to_cnt_d;
      if (ack_ok) begin
        timeout_q <= 1'b0;
      end else if (to_cnt_d == TOW'(TIMEOUT_CYC)) begin
        timeout_q <= 1'b1;
      end

      unique case (state_q)
        IDLE:    if (tx_accept) state_q <= SENDING;
        SENDING: if (TxDone) state_q <= (delay_q == '0) ? IDLE : GAP;
        GAP:     if (gap_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TxAllow     = tx_allow;
  assign Outstanding = outstanding;
  assign Timeout     = timeout_q;
  assign AckError    = ack_err_q;

endmodule

// File: tb/tb_rvvi_flow_ctrl.sv
// Self-checking bench for rvvi_flow_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_rvvi_flow_ctrl;
  import rvvi_flow_ctrl_pkg::*;

  localparam int   WINDOW  = 16;
  localparam int   TIMEOUT = 100;
  localparam cvw_t P_TB    = '{XLEN: 32'd64};

  typedef struct packed {
    logic        allow;
    logic        to;
    logic        err;
    logic [63:0] out;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, AckValid, TxStart, TxDone;
  logic [63:0] AckMinstret, TxMinstret;
  logic [15:0] AckDelay;
  logic        TxAllow, Timeout, AckError;
  logic [63:0] Outstanding;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts of in-flight work and remaining blocked cycles.
  logic [63:0] m_sent, m_acked;
  int          m_delay, m_gap, m_stall;
  bit          m_frame, m_to, m_err;

  rvvi_flow_ctrl #(
    .P(P_TB), .WINDOW(WINDOW), .DELAYW(16), .DEFAULT_DELAY(0), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .AckValid(AckValid), .AckMinstret(AckMinstret),
    .AckDelay(AckDelay), .TxStart(TxStart), .TxMinstret(TxMinstret), .TxDone(TxDone),
    .TxAllow(TxAllow), .Outstanding(Outstanding), .Timeout(Timeout), .AckError(AckError)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void model_reset();
    m_sent = '0; m_acked = '0; m_delay = 0; m_gap = 0; m_stall = 0;
    m_frame = 0; m_to = 0; m_err = 0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.out   = m_sent - m_acked;
    o.allow = !m_frame && (m_gap == 0) && (o.out < 64'(WINDOW));
    o.to    = m_to;
    o.err   = m_err;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.allow = TxAllow; o.to = Timeout; o.err = AckError; o.out = Outstanding;
    return o;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle at negedge.
  task automatic step(input bit ack_v, input logic [63:0] ack_m, input int ack_d,
                      input bit tx_s, input logic [63:0] tx_m, input bit tx_d, input bit rst);
    logic [63:0] out;
    bit allow, acc_tx, ack_ok;
    reset = rst; AckValid = ack_v; AckMinstret = ack_m; AckDelay = 16'(ack_d);
    TxStart = tx_s; TxMinstret = tx_m; TxDone = tx_d;
    @(posedge clk);
    out    = m_sent - m_acked;
    allow  = !m_frame && (m_gap == 0) && (out < 64'(WINDOW));
    acc_tx = tx_s && allow;
    ack_ok = ack_v && ((ack_m - m_acked) <= out);
    if (rst) begin
      model_reset();
    end else begin
      if (m_gap > 0) m_gap--;
      else if (m_frame && tx_d) begin m_frame = 0; m_gap = m_delay; end
      else if (acc_tx) m_frame = 1;
      if (acc_tx) m_sent = tx_m;
      if (ack_ok) begin m_acked = ack_m; m_delay = ack_d; end
      else if (ack_v) m_err = 1;
      if (ack_ok) begin m_stall = 0; m_to = 0; end
      else if (out != 0) begin m_stall++; if (m_stall >= TIMEOUT) m_to = 1; end
      else m_stall = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, '0, 0, 1);
  endtask

  task automatic test_reset();
    step(1, 64'h1234, 3, 1, 64'h55, 1, 1);
    step(1, 64'h9, 2, 1, 64'h7, 0, 1);
    n_vec++;
    if (dut_obs() !== obs_t'{1'b1, 1'b0, 1'b0, 64'd0}) begin
      n_err++; $display("FAIL reset_state: got %h want allow=1 out=0 flags=0", dut_obs());
    end
    n_vec++;
    if (dut_obs() !== model_obs()) begin
      n_err++; $display("FAIL reset_model: got %h want %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_basic_frame();
    step(0, '0, 0, 1, 64'd1, 0, 0);
    n_vec++;
    if (TxAllow !== 1'b0 || Outstanding !== 64'd1) begin
      n_err++; $display("FAIL basic_sending: allow=%b out=%0d want allow=0 out=1", TxAllow, Outstanding);
    end
    step(0, '0, 0, 0, '0, 1, 0);
    n_vec++;
    if (TxAllow !== 1'b1 || Outstanding !== 64'd1) begin
      n_err++; $display("FAIL basic_done: allow=%b out=%0d want allow=1 out=1", TxAllow, Outstanding);
    end
  endtask

  task automatic test_gap();
    int low;
    step(1, 64'd0, 5, 0, '0, 0, 0);
    step(0, '0, 0, 1, 64'd2, 0, 0);
    step(0, '0, 0, 0, '0, 1, 0);
    low = 0;
    while (TxAllow !== 1'b1 && low < 50) begin
      low++;
      if (low == 2) step(1, 64'd1, 7, 0, '0, 0, 0);
      else idle();
    end
    n_vec++;
    if (low != 5) begin
      n_err++; $display("FAIL gap_first: blocked %0d cycles want 5", low);
    end
    step(0, '0, 0, 1, 64'd3, 0, 0);
    step(0, '0, 0, 0, '0, 1, 0);
    low = 0;
    while (TxAllow !== 1'b1 && low < 50) begin
      low++;
      idle();
    end
    n_vec++;
    if (low != 7) begin
      n_err++; $display("FAIL gap_second: blocked %0d cycles want 7", low);
    end
    n_vec++;
    if (dut_obs() !== model_obs()) begin
      n_err++; $display("FAIL gap_model: got %h want %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_window();
    do_reset();
    for (int m = 1; m <= 16; m++) begin
      step(0, '0, 0, 1, 64'(m), 0, 0);
      step(0, '0, 0, 0, '0, 1, 0);
    end
    n_vec++;
    if (TxAllow !== 1'b0 || Outstanding !== 64'd16) begin
      n_err++; $display("FAIL window_full: allow=%b out=%0d want allow=0 out=16", TxAllow, Outstanding);
    end
    step(0, '0, 0, 1, 64'd17, 0, 0);
    n_vec++;
    if (dut_obs() !== model_obs() || Outstanding !== 64'd16) begin
      n_err++; $display("FAIL window_blocked_start: got %h want %h", dut_obs(), model_obs());
    end
    step(1, 64'd4, 0, 0, '0, 0, 0);
    n_vec++;
    if (TxAllow !== 1'b1 || Outstanding !== 64'd12) begin
      n_err++; $display("FAIL window_reopen: allow=%b out=%0d want allow=1 out=12", TxAllow, Outstanding);
    end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    step(0, '0, 0, 1, 64'd1, 0, 0);
    step(0, '0, 0, 0, '0, 1, 0);
    k = 1;
    while (k < TIMEOUT) begin
      idle();
      k++;
      if (k == TIMEOUT - 1) begin
        n_vec++;
        if (Timeout !== 1'b0) begin
          n_err++; $display("FAIL timeout_early: Timeout=%b at %0d want 0", Timeout, k);
        end
      end
    end
    n_vec++;
    if (Timeout !== 1'b1) begin
      n_err++; $display("FAIL timeout_rise: Timeout=%b at %0d want 1", Timeout, k);
    end
    step(1, 64'd1, 0, 0, '0, 0, 0);
    n_vec++;
    if (Timeout !== 1'b0 || Outstanding !== 64'd0) begin
      n_err++; $display("FAIL timeout_clear: Timeout=%b out=%0d want 0 0", Timeout, Outstanding);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(0, '0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    step(0, '0, 0, 0, '0, 1, 0);
    step(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    step(0, '0, 0, 0, '0, 1, 0);
    step(0, '0, 0, 1, 64'h1, 0, 0);
    step(0, '0, 0, 0, '0, 1, 0);
    n_vec++;
    if (Outstanding !== 64'd3) begin
      n_err++; $display("FAIL wrap_sent: out=%0d want 3", Outstanding);
    end
    step(1, 64'h0, 0, 0, '0, 0, 0);
    n_vec++;
    if (Outstanding !== 64'd1 || AckError !== 1'b0) begin
      n_err++; $display("FAIL wrap_ack0: out=%0d err=%b want 1 0", Outstanding, AckError);
    end
    step(1, 64'h5, 3, 0, '0, 0, 0);
    n_vec++;
    if (Outstanding !== 64'd1 || AckError !== 1'b1) begin
      n_err++; $display("FAIL wrap_ack_beyond: out=%0d err=%b want 1 1", Outstanding, AckError);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 64'd3, 0, 0, '0, 0, 0);
    for (int m = 1; m <= 2; m++) begin
      step(0, '0, 0, 1, 64'(m), 0, 0);
      step(0, '0, 0, 0, '0, 1, 0);
    end
    step(0, '0, 0, 1, 64'd3, 0, 0);
    n_vec++;
    if (dut_obs() !== obs_t'{1'b0, 1'b0, 1'b1, 64'd3}) begin
      n_err++; $display("FAIL midreset_pre: got %h want allow=0 out=3 err=1", dut_obs());
    end
    step(0, '0, 0, 0, '0, 1, 1);
    n_vec++;
    if (dut_obs() !== obs_t'{1'b1, 1'b0, 1'b0, 64'd0}) begin
      n_err++; $display("FAIL midreset_post: got %h want allow=1 out=0 flags=0", dut_obs());
    end
  endtask

  task automatic test_random();
    logic [63:0] out, off;
    bit ack_v;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out = m_sent - m_acked;
      ack_v = (c < 1500) ? ($urandom % 4 == 0) : ($urandom % 60 == 0);
      if ($urandom % 8 == 0) off = out + 64'($urandom_range(1, 3));
      else if (out != 0) off = 64'($urandom) % (out + 64'd1);
      else off = '0;
      step(ack_v, m_acked + off, $urandom_range(0, 4),
           $urandom % 2 == 1, m_sent + 64'($urandom_range(1, 2)),
           $urandom % 3 == 0, $urandom % 700 == 0);
      n_vec++;
      if (dut_obs() !== model_obs()) begin
        n_err++; $display("FAIL random_c%0d: got %h want %h", c, dut_obs(), model_obs());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_gap();
    test_window();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
